// File: rtl/button_input_unit.sv
// Player-input front end for the Genius game. Each raw button is synchronised and debounced.
// A small FSM then turns each clean press into one encoded, handshaked event.
module button_input_unit #(
    parameter  int NUM_BUTTONS     = 4,
    parameter  int DEBOUNCE_CYCLES = 4,
    localparam int IDX_W           = $clog2(NUM_BUTTONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   player_wr,
    input  logic [NUM_BUTTONS-1:0] buttons_i,
    input  logic                   press_ready,
    output logic                   press_valid,
    output logic [IDX_W-1:0]       press_idx,
    output logic                   multi_press,
    output logic                   busy
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]       CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_BUTTONS-1:0] ONE_VEC = NUM_BUTTONS'(1);

    typedef enum logic [1:0] {
        S_DISABLED,
        S_WAIT_REL,
        S_ARMED,
        S_OUTPUT
    } state_t;

    logic [NUM_BUTTONS-1:0] r_sync1;
    logic [NUM_BUTTONS-1:0] r_sync2;
    logic [NUM_BUTTONS-1:0] w_stable;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_press_valid;
    logic             w_press_valid_next;
    logic [IDX_W-1:0] r_press_idx;
    logic [IDX_W-1:0] w_press_idx_next;
    logic             r_multi_press;
    logic             w_multi_press_next;

    logic [IDX_W-1:0] w_enc_idx;
    logic             w_any;
    logic             w_one_hot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= buttons_i;
            r_sync2 <= r_sync1;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles.
    generate
        for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_debounce
            logic [CNT_W-1:0] r_cnt;
            logic             r_stable_bit;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt        <= '0;
                    r_stable_bit <= 1'b0;
                end else if (r_sync2[gi] != r_stable_bit) begin
                    if (r_cnt == CNT_MAX) begin
                        r_stable_bit <= r_sync2[gi];
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign w_stable[gi] = r_stable_bit;
        end
    endgenerate

    always_comb begin
        w_enc_idx = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (w_stable[i]) begin
                w_enc_idx = IDX_W'(i);
            end
        end
    end

    assign w_any     = (w_stable != '0);
    assign w_one_hot = w_any && ((w_stable & (w_stable - ONE_VEC)) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_DISABLED;
            r_press_valid <= 1'b0;
            r_press_idx   <= '0;
            r_multi_press <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_press_valid <= w_press_valid_next;
            r_press_idx   <= w_press_idx_next;
            r_multi_press <= w_multi_press_next;
        end
    end

    // Closing the window wins over any handshake or detection in the same cycle.
    always_comb begin
        w_state_next       = r_state;
        w_press_valid_next = r_press_valid;
        w_press_idx_next   = r_press_idx;
        w_multi_press_next = 1'b0;

        if (!player_wr) begin
            w_state_next       = S_DISABLED;
            w_press_valid_next = 1'b0;
        end else begin
            case (r_state)
                S_DISABLED: begin
                    w_state_next = S_WAIT_REL;
                end
                S_WAIT_REL: begin
                    if (!w_any) begin
                        w_state_next = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (w_one_hot) begin
                        w_press_idx_next   = w_enc_idx;
                        w_press_valid_next = 1'b1;
                        w_state_next       = S_OUTPUT;
                    end else if (w_any) begin
                        w_multi_press_next = 1'b1;
                        w_state_next       = S_WAIT_REL;
                    end
                end
                S_OUTPUT: begin
                    if (press_ready) begin
                        w_press_valid_next = 1'b0;
                        w_state_next       = S_WAIT_REL;
                    end
                end
                default: begin
                    w_state_next       = S_DISABLED;
                    w_press_valid_next = 1'b0;
                end
            endcase
        end
    end

    assign press_valid = r_press_valid;
    assign press_idx   = r_press_idx;
    assign multi_press = r_multi_press;
    assign busy        = (r_state != S_DISABLED);

endmodule
